// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose:
//    Merges two writeback sources (ALU "A" and load "B") onto the single
//    register-file write port. One request is granted per cycle. The granted
//    destination and data are registered, so the register file sees a one-cycle
//    RegWr pulse with stable RW/BusW that it samples at the falling edge.
//    Writes that target X31 are accepted but suppressed. Each suppressed write
//    increments the saturating DropCnt counter.
//
// Arbitration policy (compile-time):
//    REGARB_ROUND_ROBIN_EN undefined : fixed priority to A. B is promoted once
//                                      it has waited MAX_WAIT cycles.
//    REGARB_ROUND_ROBIN_EN defined   : alternate between A and B on contention.
//                                      The requester not granted last wins.
//
// Parameters:
//    DATA_W   - register data width
//    MAX_WAIT - starvation limit for B under fixed priority (1..15)
//
// Ports:
//    Clk              - clock. All state updates on the rising edge.
//    Reset_n          - synchronous, active-low reset
//    Stall            - write port unavailable this cycle (no grants)
//    A_Valid/A_Rd/A_Data/A_Ready - ALU writeback request channel
//    B_Valid/B_Rd/B_Data/B_Ready - load writeback request channel
//    RegWr            - register-file write enable (registered)
//    RW               - register-file write address (registered)
//    BusW             - register-file write data (registered)
//    DropCnt          - saturating count of accepted writes to X31
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Stall,
   input  logic              A_Valid,
   input  logic [4:0]        A_Rd,
   input  logic [DATA_W-1:0] A_Data,
   output logic              A_Ready,
   input  logic              B_Valid,
   input  logic [4:0]        B_Rd,
   input  logic [DATA_W-1:0] B_Data,
   output logic              B_Ready,
   output logic              RegWr,
   output logic [4:0]        RW,
   output logic [DATA_W-1:0] BusW,
   output logic [7:0]        DropCnt
);

   // Writes to this register are accepted but never reach the register file.
   localparam logic [4:0] DROP_RD   = 5'd31;
   localparam logic [7:0] DROP_MAX  = 8'hFF;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   logic              reg_wr_reg,   reg_wr_next;
   logic [4:0]        rw_reg,       rw_next;
   logic [DATA_W-1:0] bus_w_reg,    bus_w_next;
   logic [7:0]        drop_cnt_reg, drop_cnt_next;

   // ------------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------------
   logic port_open;     // grants allowed this cycle
   logic pick_b;        // contention tie-break: 1 = B wins when both valid
   logic grant_a;
   logic grant_b;
   logic a_xfer;
   logic b_xfer;
   logic xfer;

`ifdef REGARB_ROUND_ROBIN_EN
   // Source encoding of the most recent transfer.
   localparam logic [0:0] GRANT_A = 1'b0;
   localparam logic [0:0] GRANT_B = 1'b1;

   logic [0:0] last_grant_reg, last_grant_next;

   // On contention the side that was not served last goes next.
   assign pick_b = (last_grant_reg == GRANT_A);

   always_comb begin
      last_grant_next = last_grant_reg;
      if (b_xfer) begin
         last_grant_next = GRANT_B;
      end else if (a_xfer) begin
         last_grant_next = GRANT_A;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         // B counts as served last, so the first contention after reset goes to A.
         last_grant_reg <= GRANT_B;
      end else begin
         last_grant_reg <= last_grant_next;
      end
   end
`else
   localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

   // Cycles for which B has been valid and not granted.
   logic [3:0] wait_cnt_reg, wait_cnt_next;

   // A wins contention until B has waited long enough.
   assign pick_b = (wait_cnt_reg >= MAX_WAIT_L);

   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (!Stall) begin
         if (B_Valid && !b_xfer) begin
            // Saturate so a very long wait cannot wrap back below the limit.
            if (wait_cnt_reg != 4'hF) begin
               wait_cnt_next = wait_cnt_reg + 4'd1;
            end
         end else begin
            wait_cnt_next = 4'd0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wait_cnt_reg <= 4'd0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
      end
   end
`endif

   // Ready is purely combinational, and it is forced low during reset or stall
   // so a requester never sees a handshake that the write stage drops.
   assign port_open = Reset_n & ~Stall;
   assign grant_a   = A_Valid & (~B_Valid | ~pick_b);
   assign grant_b   = B_Valid & (~A_Valid |  pick_b);
   assign A_Ready   = grant_a & port_open;
   assign B_Ready   = grant_b & port_open;

   assign a_xfer    = A_Valid & A_Ready;
   assign b_xfer    = B_Valid & B_Ready;
   assign xfer      = a_xfer | b_xfer;

   // ------------------------------------------------------------------------
   // Selected request. The grants are exclusive, so b_xfer alone decides.
   // ------------------------------------------------------------------------
   logic [4:0]        sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              sel_drop;

   assign sel_rd   = b_xfer ? B_Rd   : A_Rd;
   assign sel_data = b_xfer ? B_Data : A_Data;
   assign sel_drop = (sel_rd == DROP_RD);

   // ------------------------------------------------------------------------
   // Write stage
   // ------------------------------------------------------------------------
   always_comb begin
      reg_wr_next   = 1'b0;
      rw_next       = rw_reg;
      bus_w_next    = bus_w_reg;
      drop_cnt_next = drop_cnt_reg;

      if (xfer) begin
         if (sel_drop) begin
            // Consumed without a write. RW/BusW keep the last real write.
            if (drop_cnt_reg != DROP_MAX) begin
               drop_cnt_next = drop_cnt_reg + 8'd1;
            end
         end else begin
            reg_wr_next = 1'b1;
            rw_next     = sel_rd;
            bus_w_next  = sel_data;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         // Any write already captured is discarded here.
         reg_wr_reg   <= 1'b0;
         rw_reg       <= 5'd0;
         bus_w_reg    <= '0;
         drop_cnt_reg <= 8'd0;
      end else begin
         reg_wr_reg   <= reg_wr_next;
         rw_reg       <= rw_next;
         bus_w_reg    <= bus_w_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   assign RegWr   = reg_wr_reg;
   assign RW      = rw_reg;
   assign BusW    = bus_w_reg;
   assign DropCnt = drop_cnt_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Purpose:
//    Directed self-checking bench for reg_write_arbiter with default
//    parameters (DATA_W=64, MAX_WAIT=4). The tests follow the
//    REGARB_ROUND_ROBIN_EN setting of the build. Inputs change 1 time unit
//    after a rising edge. Ready is checked before the next edge, and the
//    registered outputs are checked 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

   localparam int DATA_W = 64;

   logic              Clk = 1'b0;
   logic              Reset_n;
   logic              Stall;
   logic              A_Valid;
   logic [4:0]        A_Rd;
   logic [DATA_W-1:0] A_Data;
   logic              A_Ready;
   logic              B_Valid;
   logic [4:0]        B_Rd;
   logic [DATA_W-1:0] B_Data;
   logic              B_Ready;
   logic              RegWr;
   logic [4:0]        RW;
   logic [DATA_W-1:0] BusW;
   logic [7:0]        DropCnt;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   reg_write_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Stall   (Stall),
      .A_Valid (A_Valid),
      .A_Rd    (A_Rd),
      .A_Data  (A_Data),
      .A_Ready (A_Ready),
      .B_Valid (B_Valid),
      .B_Rd    (B_Rd),
      .B_Data  (B_Data),
      .B_Ready (B_Ready),
      .RegWr   (RegWr),
      .RW      (RW),
      .BusW    (BusW),
      .DropCnt (DropCnt)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin : stim
      logic [9:0] pat;
      logic       use_b;

      Reset_n = 1'b0; Stall = 1'b0;
      A_Valid = 1'b0; A_Rd = 5'd0; A_Data = '0;
      B_Valid = 1'b0; B_Rd = 5'd0; B_Data = '0;
      tick();
      tick();

      // Reset state. Ready stays low during reset even with a valid request.
      A_Valid = 1'b1; A_Rd = 5'd5; A_Data = 64'h1234;
      #1;
      chk("rst_a_ready", A_Ready, 0);
      tick();
      chk("rst_regwr",   RegWr,   0);
      chk("rst_rw",      RW,      0);
      chk("rst_busw",    BusW,    0);
      chk("rst_dropcnt", DropCnt, 0);
`ifndef REGARB_ROUND_ROBIN_EN
      chk("rst_waitcnt", dut.wait_cnt_reg, 0);
`endif

      // Single A write accepted on the first edge after reset is released.
      Reset_n = 1'b1;
      #1;
      chk("a1_a_ready", A_Ready, 1);
      chk("a1_b_ready", B_Ready, 0);
      tick();
      chk("a1_regwr", RegWr, 1);
      chk("a1_rw",    RW,    5);
      chk("a1_busw",  BusW,  64'h1234);
      A_Valid = 1'b0;
      #1;
      chk("idle_a_ready", A_Ready, 0);
      tick();
      chk("idle_regwr", RegWr, 0);
      chk("idle_rw",    RW,    5);
      chk("idle_busw",  BusW,  64'h1234);

      // X31 writes from B are consumed silently, and DropCnt saturates.
      B_Valid = 1'b1; B_Rd = 5'd31; B_Data = 64'hDEAD;
      #1;
      for (int i = 0; i < 300; i++) begin
         if (i < 3) chk("x31_b_ready", B_Ready, 1);
         tick();
         if (i < 3)   chk("x31_regwr", RegWr, 0);
         if (i == 2)  chk("x31_drop3", DropCnt, 3);
         if (i == 254) chk("x31_drop255", DropCnt, 255);
      end
      chk("x31_drop300", DropCnt, 255);
      B_Valid = 1'b0;
      tick();

      // Single B write.
      B_Valid = 1'b1; B_Rd = 5'd7; B_Data = 64'hBBBB;
      #1;
      chk("b1_b_ready", B_Ready, 1);
      chk("b1_a_ready", A_Ready, 0);
      tick();
      chk("b1_regwr", RegWr, 1);
      chk("b1_rw",    RW,    7);
      chk("b1_busw",  BusW,  64'hBBBB);
      B_Valid = 1'b0;

      // Back-to-back A writes with no bubble.
      A_Valid = 1'b1; A_Rd = 5'd1; A_Data = 64'h11;
      tick();
      chk("b2b1_regwr", RegWr, 1);
      chk("b2b1_rw",    RW,    1);
      A_Rd = 5'd2; A_Data = 64'h22;
      tick();
      chk("b2b2_regwr", RegWr, 1);
      chk("b2b2_rw",    RW,    2);
      chk("b2b2_busw",  BusW,  64'h22);
      A_Valid = 1'b0;
      tick();
      chk("b2b_end_regwr", RegWr, 0);

      // Continuous contention on the same Rd after a fresh reset.
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
`ifdef REGARB_ROUND_ROBIN_EN
      pat = 10'b1010101010;   // bit i = 1 means B wins cycle i: A,B,A,B,...
`else
      pat = 10'b1000010000;   // A,A,A,A,B repeating
`endif
      A_Valid = 1'b1; A_Rd = 5'd3; A_Data = 64'hAAAA;
      B_Valid = 1'b1; B_Rd = 5'd3; B_Data = 64'hBBBB;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("cont%0d_a_ready", i), A_Ready, !pat[i]);
         chk($sformatf("cont%0d_b_ready", i), B_Ready, pat[i]);
         tick();
         chk($sformatf("cont%0d_regwr", i), RegWr, 1);
         chk($sformatf("cont%0d_busw", i), BusW, pat[i] ? 64'hBBBB : 64'hAAAA);
      end
      // The last grant (B in both policies) holds the final value for Rd 3.
      chk("cont_final_rw",   RW,   3);
      chk("cont_final_busw", BusW, 64'hBBBB);
      A_Valid = 1'b0; B_Valid = 1'b0;
      tick();

      // Stall while A is valid. Under fixed priority B also waits, so the
      // held wait count can be observed.
`ifdef REGARB_ROUND_ROBIN_EN
      use_b = 1'b0;
`else
      use_b = 1'b1;
`endif
      A_Valid = 1'b1; A_Rd = 5'd9; A_Data = 64'h99;
      B_Valid = use_b; B_Rd = 5'd10; B_Data = 64'h1010;
      tick();
      tick();
`ifndef REGARB_ROUND_ROBIN_EN
      chk("pre_stall_waitcnt", dut.wait_cnt_reg, 2);
`endif
      Stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d_a_ready", i), A_Ready, 0);
         chk($sformatf("stall%0d_b_ready", i), B_Ready, 0);
         tick();
         chk($sformatf("stall%0d_regwr", i), RegWr, 0);
`ifndef REGARB_ROUND_ROBIN_EN
         chk($sformatf("stall%0d_waitcnt", i), dut.wait_cnt_reg, 2);
`endif
      end
      Stall = 1'b0;
      #1;
      chk("unstall_a_ready", A_Ready, 1);
      tick();
      chk("unstall_regwr", RegWr, 1);
      chk("unstall_rw",    RW,    9);
      chk("unstall_busw",  BusW,  64'h99);

      // Reset on the cycle after a grant discards the pending write.
      B_Valid = 1'b0;
      A_Rd = 5'd4; A_Data = 64'h44;
      tick();
      chk("mid_grant_regwr", RegWr, 1);
      chk("mid_grant_rw",    RW,    4);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_a_ready", A_Ready, 0);
      tick();
      chk("mid_rst_regwr",   RegWr,   0);
      chk("mid_rst_dropcnt", DropCnt, 0);
      chk("mid_rst_rw",      RW,      0);
      chk("mid_rst_busw",    BusW,    0);
      Reset_n = 1'b1;
      A_Valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, fixed-priority starvation limit in cycles (1..15).
REQ-003 SHALL have port Clk, input, 1, single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port Stall, input, 1, write port unavailable this cycle.
REQ-006 SHALL have port A_Valid, input, 1, ALU writeback request.
REQ-007 SHALL have port A_Rd, input, 5, ALU destination register.
REQ-008 SHALL have port A_Data, input, DATA_W, ALU result.
REQ-009 SHALL have port A_Ready, output, 1, ALU request accepted this cycle.
REQ-010 SHALL have ports B_Valid, B_Rd, B_Data and B_Ready for load writeback, with widths and meanings as for A.
REQ-011 SHALL have port RegWr, output, 1, register-file write enable.
REQ-012 SHALL have port RW, output, 5, register-file write address.
REQ-013 SHALL have port BusW, output, DATA_W, register-file write data.
REQ-014 SHALL have port DropCnt, output, 8, saturating count of accepted writes to X31.

Function
REQ-015 SHALL make A_Ready and B_Ready combinational; at most one SHALL be high per cycle, and both SHALL be 0 when Stall=1 or Reset_n=0.
REQ-016 SHALL complete a transfer on a posedge with Valid=1 and Ready=1; requesters hold Rd/Data stable while Valid=1 and Ready=0.
REQ-017 SHALL grant the only valid requester when exactly one is valid and Stall=0.
REQ-018 SHALL register the granted Rd and Data into RW and BusW, driving RegWr=1 for exactly the following cycle, giving a latency of 1 cycle; outputs stay stable the whole cycle so the register file samples them at negedge.
REQ-019 SHALL drive RegWr=0 in any cycle following a cycle with no transfer; RW and BusW SHALL then hold their last values.
REQ-020 SHALL accept a transfer with Rd=31 (Ready=1) but SHALL NOT assert RegWr for it, and SHALL increment DropCnt, saturating at 255.
REQ-021 SHALL present back-to-back grants as consecutive RegWr pulses, one per cycle, with no bubble.
REQ-022 SHALL order writes when both requesters target the same Rd strictly by grant order; the later grant's data is the final register value.
REQ-023 SHALL keep WaitCnt (4 bits): when B_Valid=1 and B is not granted, increment; when B is granted or B_Valid=0, clear.
REQ-024 SHALL NOT advance WaitCnt while Stall=1; it holds.

Reset
REQ-025 SHALL, on a posedge with Reset_n=0, set RegWr=0, RW=0, BusW=0, DropCnt=0, WaitCnt=0 and LastGrant=B.
REQ-026 SHALL discard a write in flight when reset is asserted mid-operation; RegWr SHALL be 0 in the cycle after the reset edge.
REQ-027 SHALL accept the first request on the first posedge with Reset_n=1.

Configuration
REQ-028 SHALL use macro REGARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-029 SHALL, when the macro is defined and both requesters are valid, grant the requester that is not LastGrant, updating LastGrant on every transfer; MAX_WAIT and WaitCnt are then unused and their logic is compiled out.
REQ-030 SHALL, when the macro is undefined and both requesters are valid, grant A, unless WaitCnt >= MAX_WAIT, in which case B is granted.

Verification
REQ-031 SHALL cover: A_Valid=1, A_Rd=5, A_Data=0x1234, one cycle -> A_Ready=1, and the next cycle RegWr=1, RW=5, BusW=0x1234.
REQ-032 SHALL cover: B_Valid=1, B_Rd=31 for 3 transfers -> RegWr stays 0 and DropCnt=3; 300 such transfers -> DropCnt=255.
REQ-033 SHALL cover: A and B both valid continuously, fixed priority, MAX_WAIT=4 -> grant sequence A,A,A,A,B repeating.
REQ-034 SHALL cover: A and B both valid continuously with REGARB_ROUND_ROBIN_EN defined -> after reset, grant sequence A,B,A,B.
REQ-035 SHALL cover: Stall=1 for 3 cycles while A is valid -> A_Ready=0, RegWr=0 and WaitCnt held; the write appears one cycle after Stall drops.
REQ-036 SHALL cover: Reset_n=0 on the cycle after a grant -> RegWr=0 on the next cycle and DropCnt=0.
